bcd_clock_core: RTL
===================

Name: bcd_clock_core

Overview:
- Parametrised, single-clock BCD time-of-day counter. Replaces the ripple-clocked digit chain and derived 1 Hz/fast clocks with a fully synchronous tick-enable design.
- Adds 12/24-hour mode, an external RTC pulse-per-second source, validated time loading, and event strobes.
- Sits between board I/O (CLK, BTN, RTC square wave) and the LED/WS2812 display-formatting logic, which consume its digit bus and strobes.

Parameters:
- CLK_HZ, 12000000, CLK frequency; internal prescaler divides by this for a 1 s tick.
- FAST_DIV, 1000, speed-up factor while FAST=1; fast tick period = CLK_HZ/FAST_DIV cycles (integer, >=1).
- HOUR_24, 1, 1 = hours 00..23; 0 = hours 01..12 with PM flag.
- USE_EXT_PPS, 0, 1 = normal-rate ticks come from EXT_PPS rising edges; 0 = internal prescaler.

Ports:
- CLK  in  1  system clock
- RST_N  in  1  asynchronous active-low reset
- EXT_PPS  in  1  RTC 1 Hz square wave, asynchronous to CLK
- RUN  in  1  count enable; 0 freezes time, prescaler held at 0
- FAST  in  1  fast-advance mode (internal divisor, regardless of USE_EXT_PPS)
- LOAD  in  1  load request, sampled every cycle
- LOAD_TIME  in  24  BCD {h1,h0,m1,m0,s1,s0}, 4 bits each
- LOAD_PM  in  1  PM flag to load (ignored when HOUR_24=1)
- TIME  out  24  current BCD {h1,h0,m1,m0,s1,s0}
- PM  out  1  PM flag; constant 0 when HOUR_24=1
- TICK  out  1  one-cycle strobe, coincident with each TIME advance
- MIN_EVT  out  1  one-cycle strobe when seconds wrap 59->00
- HOUR_EVT  out  1  one-cycle strobe when mm:ss wraps 59:59->00:00
- NOON_MID  out  1  level; high when the displayed time is hh:00 with hh = 00 or 12
- LOAD_ACK  out  1  one-cycle strobe; load accepted
- LOAD_ERR  out  1  one-cycle strobe; load rejected

Behaviour:
- Reset (async assert, sync release):
  - TIME = 00:00:00 if HOUR_24, else 12:00:00 with PM=0.
  - All strobes 0. Prescaler 0. PPS synchroniser flops 0.
- Tick source:
  - Internal: counter counts 0..TERM-1, then wraps to 0 and raises an internal tick for one cycle. TERM = CLK_HZ, or CLK_HZ/FAST_DIV when FAST=1.
  - Any change of FAST clears the prescaler in that cycle.
  - External (USE_EXT_PPS=1, FAST=0): EXT_PPS passes through a 2-flop synchroniser plus edge detector. Each rising edge gives one tick, 3-cycle latency from pin to tick. The prescaler is unused in this case.
- Advance, when tick & RUN:
  - Registered: TIME, TICK, MIN_EVT and HOUR_EVT all update on the cycle after the internal tick, i.e. 1-cycle latency.
  - s0 counts 0..9; s1 0..5; m0 0..9; m1 0..5. Each digit wraps to 0 and carries to the next.
  - Hours, HOUR_24=1: 23 -> 00.
  - Hours, HOUR_24=0: 11 -> 12 toggles PM; 12 -> 01; otherwise increment. BCD carry h0 9 -> 0 increments h1.
  - A tick arriving while RUN=0 is discarded, not queued.
- Load:
  - LOAD=1 validates LOAD_TIME combinationally.
  - Valid means: every digit <=9, s1<=5, m1<=5, and hours 00..23 (HOUR_24) or 01..12 (12 h).
  - Valid: next cycle TIME=LOAD_TIME, PM=LOAD_PM, prescaler cleared, LOAD_ACK=1.
  - Invalid: TIME unchanged, LOAD_ERR=1, prescaler unaffected.
  - LOAD held high repeats the action every cycle.
  - LOAD and tick in the same cycle: a valid load wins, the tick is dropped, and TICK/MIN_EVT/HOUR_EVT stay 0. An invalid load does not block the tick.
- NOON_MID:
  - Combinational from registered state.
  - High when m1=m0=0 and hours are 00 or 12 (HOUR_24), or hours are 12 (12 h mode).
- Reset mid-operation: outputs return to reset values immediately. Any in-flight tick or load is lost.

Test Plan:
- CLK_HZ=10, HOUR_24=1, RUN=1, release reset -> TIME=0x000000; first TICK 10 cycles after reset release; TIME=0x000001. Check TICK spacing stays 10 cycles.
- Load 0x235959 -> LOAD_ACK next cycle. Next tick gives TIME=0x000000 with TICK, MIN_EVT and HOUR_EVT all high for one cycle; NOON_MID goes high.
- HOUR_24=0: load 0x115959, PM=0 -> next tick gives 0x120000, PM=1, NOON_MID=1. Load 0x125959 -> next tick gives 0x010000, PM unchanged.
- Invalid loads 0x246000, 0x00A000, and (12 h mode) 0x000000 -> LOAD_ERR pulse each time, TIME unchanged. Valid load asserted on a tick cycle -> loaded value held, no TICK.
- FAST=1 with FAST_DIV=5, CLK_HZ=10 -> TICK every 2 cycles. Toggle FAST mid-count -> prescaler restarts, next TICK TERM cycles later. RUN=0 -> TIME frozen, no strobes.
- USE_EXT_PPS=1: drive EXT_PPS square wave asynchronously -> exactly one TICK per rising edge, 3–4 cycles after the edge. Assert RST_N low mid-count -> TIME=0x000000 without waiting for a CLK edge.

Source files
------------

// File: rtl/bcd_clock_core.sv
// Synchronous BCD time-of-day counter with 12/24 h modes, optional external PPS, validated load.
// Latency: TIME and strobes update 1 cycle after the internal tick; EXT_PPS pin to TICK is 3 cycles.
// Backpressure: none; a tick while RUN=0 or coincident with a valid load is dropped, never queued.
module bcd_clock_core #(
  parameter int CLK_HZ      = 12000000,
  parameter int FAST_DIV    = 1000,
  parameter int HOUR_24     = 1,
  parameter int USE_EXT_PPS = 0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        ext_pps_i,
  input  logic        run_i,
  input  logic        fast_i,
  input  logic        load_i,
  input  logic [23:0] load_time_i,
  input  logic        load_pm_i,
  output logic [23:0] time_o,
  output logic        pm_o,
  output logic        tick_o,
  output logic        min_evt_o,
  output logic        hour_evt_o,
  output logic        noon_mid_o,
  output logic        load_ack_o,
  output logic        load_err_o
);

  localparam int FAST_TERM = ((CLK_HZ / FAST_DIV) < 1) ? 1 : (CLK_HZ / FAST_DIV);
  localparam int CW        = ($clog2(CLK_HZ) > 0) ? $clog2(CLK_HZ) : 1;
  localparam logic [CW-1:0] NORM_MAX = CW'(CLK_HZ - 1);
  localparam logic [CW-1:0] FAST_MAX = CW'(FAST_TERM - 1);
  localparam logic [23:0]   RST_TIME = (HOUR_24 != 0) ? 24'h000000 : 24'h120000;

  logic [23:0]   time_q;
  logic          pm_q;
  logic [CW-1:0] presc_q, presc_d;
  logic          fast_q;
  logic          pps_s1_q, pps_s2_q, pps_s3_q;
  logic          tick_q, min_evt_q, hour_evt_q, ack_q, err_q;

  // Current digits
  logic [3:0] h1, h0, m1, m0, s1, s0;
  assign {h1, h0, m1, m0, s1, s0} = time_q;

  // Load-request digits
  logic [3:0] l_h1, l_h0, l_m1, l_m0, l_s1, l_s0;
  assign {l_h1, l_h0, l_m1, l_m0, l_s1, l_s0} = load_time_i;

  logic dig_ok, hr_ok, load_valid, load_bad;
  logic use_ext, fast_chg, int_tick, ext_tick, src_tick, adv;
  logic [CW-1:0] presc_max;

  // Load validation: all digits decimal, minutes/seconds tens <= 5, hours in range for the mode
  always_comb begin
    dig_ok = (l_h1 <= 4'd9) && (l_h0 <= 4'd9) && (l_m1 <= 4'd5) &&
             (l_m0 <= 4'd9) && (l_s1 <= 4'd5) && (l_s0 <= 4'd9);
    if (HOUR_24 != 0) hr_ok = (load_time_i[23:16] <= 8'h23);
    else              hr_ok = ((l_h1 == 4'd0) && (l_h0 != 4'd0)) ||
                              ((l_h1 == 4'd1) && (l_h0 <= 4'd2));
    load_valid = load_i && dig_ok && hr_ok;
    load_bad   = load_i && !load_valid;
  end

  // Tick source selection; FAST always uses the internal divisor even in PPS mode
  always_comb begin
    use_ext   = (USE_EXT_PPS != 0) && !fast_i;
    fast_chg  = fast_i ^ fast_q;
    presc_max = fast_i ? FAST_MAX : NORM_MAX;
    int_tick  = run_i && !use_ext && !fast_chg && (presc_q == presc_max);
    ext_tick  = pps_s2_q && !pps_s3_q;
    src_tick  = use_ext ? ext_tick : int_tick;
    adv       = src_tick && run_i && !load_valid;
    if (load_valid || !run_i || use_ext || fast_chg || (presc_q >= presc_max))
      presc_d = '0;
    else
      presc_d = presc_q + CW'(1);
  end

  logic       wrap_s0, wrap_s1, wrap_m0, wrap_m1;
  logic [3:0] n_s0, n_s1, n_m0, n_m1;
  logic [7:0] n_hr;
  logic       n_pm;

  // Next time value for one-second advance, with ripple carries between digits
  always_comb begin
    wrap_s0 = (s0 == 4'd9);
    wrap_s1 = wrap_s0 && (s1 == 4'd5);
    wrap_m0 = wrap_s1 && (m0 == 4'd9);
    wrap_m1 = wrap_m0 && (m1 == 4'd5);
    n_s0 = wrap_s0 ? 4'd0 : s0 + 4'd1;
    n_s1 = wrap_s0 ? ((s1 == 4'd5) ? 4'd0 : s1 + 4'd1) : s1;
    n_m0 = wrap_s1 ? ((m0 == 4'd9) ? 4'd0 : m0 + 4'd1) : m0;
    n_m1 = wrap_m0 ? ((m1 == 4'd5) ? 4'd0 : m1 + 4'd1) : m1;
    n_hr = {h1, h0};
    n_pm = pm_q;
    if (wrap_m1) begin
      if ((HOUR_24 != 0) && ({h1, h0} == 8'h23)) begin
        n_hr = 8'h00;
      end else if ((HOUR_24 == 0) && ({h1, h0} == 8'h11)) begin
        n_hr = 8'h12;
        n_pm = !pm_q;
      end else if ((HOUR_24 == 0) && ({h1, h0} == 8'h12)) begin
        n_hr = 8'h01;
      end else if (h0 == 4'd9) begin
        n_hr = {h1 + 4'd1, 4'd0};
      end else begin
        n_hr = {h1, h0 + 4'd1};
      end
    end
  end

  // State, synchroniser and registered strobes
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      time_q     <= RST_TIME;
      pm_q       <= 1'b0;
      presc_q    <= '0;
      fast_q     <= 1'b0;
      pps_s1_q   <= 1'b0;
      pps_s2_q   <= 1'b0;
      pps_s3_q   <= 1'b0;
      tick_q     <= 1'b0;
      min_evt_q  <= 1'b0;
      hour_evt_q <= 1'b0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      pps_s1_q   <= ext_pps_i;
      pps_s2_q   <= pps_s1_q;
      pps_s3_q   <= pps_s2_q;
      fast_q     <= fast_i;
      presc_q    <= presc_d;
      tick_q     <= adv;
      min_evt_q  <= adv && wrap_s1;
      hour_evt_q <= adv && wrap_m1;
      ack_q      <= load_valid;
      err_q      <= load_bad;
      if (load_valid) begin
        time_q <= load_time_i;
        pm_q   <= (HOUR_24 != 0) ? 1'b0 : load_pm_i;
      end else if (adv) begin
        time_q <= {n_hr, n_m1, n_m0, n_s1, n_s0};
        pm_q   <= n_pm;
      end
    end
  end

  assign time_o     = time_q;
  assign pm_o       = pm_q;
  assign tick_o     = tick_q;
  assign min_evt_o  = min_evt_q;
  assign hour_evt_o = hour_evt_q;
  assign load_ack_o = ack_q;
  assign load_err_o = err_q;
  assign noon_mid_o = (m1 == 4'd0) && (m0 == 4'd0) &&
                      ((HOUR_24 != 0) ? (({h1, h0} == 8'h00) || ({h1, h0} == 8'h12))
                                      : ({h1, h0} == 8'h12));

endmodule
